// File: rtl/level_pkg.sv
// Shared types and constants for the pick-band lock levels.
package level_pkg;

  // Level sequencer states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEEK,
    S_HOLD,
    S_PIN_OK,
    S_DONE,
    S_FAIL
  } state_t;

  // 8-bit Fibonacci LFSR feedback taps 8,6,5,4 (bits 7,5,4,3). This tap set is maximal length.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  // Number of bits needed to hold a band index for n bands.
  function automatic int band_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/band_quantizer.sv
// Maps a pick Y pixel to one of NUM_BANDS equal-height bands, registered.
// A compare chain is used instead of a divider; the last threshold crossed wins.
module band_quantizer #(
  parameter int NUM_BANDS = 32,
  parameter int BAND_H    = 14,
  parameter int Y_TOP     = 32
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [9:0] pickY,
  output logic [5:0] bandIdx,
  output logic       bandValid
);

  localparam int Y_END = Y_TOP + NUM_BANDS * BAND_H;

  logic [5:0] bandIdx_d, bandIdx_q;
  logic       bandValid_d, bandValid_q;
  int         py;

  assign py = int'({22'd0, pickY});

  // Band decode: outside the band area the index is forced to 0.
  always_comb begin
    bandIdx_d   = '0;
    bandValid_d = 1'b0;
    if ((py >= Y_TOP) && (py < Y_END)) begin
      bandValid_d = 1'b1;
      for (int k = 1; k < NUM_BANDS; k++) begin
        if (py >= Y_TOP + k * BAND_H) begin
          bandIdx_d = 6'(k);
        end
      end
    end
  end

  // Output register: one cycle of latency from pickY.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bandIdx_q   <= '0;
      bandValid_q <= 1'b0;
    end else begin
      bandIdx_q   <= bandIdx_d;
      bandValid_q <= bandValid_d;
    end
  end

  assign bandIdx   = bandIdx_q;
  assign bandValid = bandValid_q;

endmodule

// File: rtl/level_pick_seq.sv
// Multi-pin pick level: draw a random target band per pin, the player presses
// openner on that band and holds it for HOLD_CYC frames. Misses lead to fail.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for levelStart
//   S_LOAD   | stepping LFSR until a legal target band is drawn
//   S_SEEK   | waiting for a press; a press off-target counts as a miss
//   S_HOLD   | openner held on target, counting frame ticks
//   S_PIN_OK | pin cleared; advance to next pin or finish
//   S_DONE   | all pins cleared, levelDone held
//   S_FAIL   | misses exhausted, levelFail held
module level_pick_seq
  import level_pkg::*;
#(
  parameter int         NUM_BANDS  = 32,
  parameter int         BAND_H     = 14,
  parameter int         Y_TOP      = 32,
  parameter int         NUM_PINS   = 3,
  parameter int         HOLD_CYC   = 30,
  parameter int         MAX_MISSES = 3,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       levelStart,
  input  logic       openner,
  input  logic [9:0] pickY,
  input  logic       frame_tick,
  output logic       levelDone,
  output logic       levelFail,
  output logic [5:0] curTarget,
  output logic [5:0] bandIdx,
  output logic       bandValid,
  output logic [2:0] pinIdx,
  output logic [2:0] missCount,
  output logic [7:0] holdProg
);

  localparam int         BW        = band_w(NUM_BANDS);
  localparam logic [7:0] CAND_MASK = 8'((1 << BW) - 1);
  localparam logic [6:0] NB7       = 7'(NUM_BANDS);
  localparam logic [2:0] LAST_PIN  = 3'(NUM_PINS - 1);
  localparam logic [7:0] HOLD_8    = 8'(HOLD_CYC);
  localparam logic [2:0] MAX_M3    = 3'(MAX_MISSES);

  state_t     state_d, state_q;
  logic [7:0] lfsr_d, lfsr_q;
  logic [5:0] curTarget_d, curTarget_q;
  logic [2:0] pinIdx_d, pinIdx_q;
  logic [2:0] missCount_d, missCount_q;
  logic [7:0] holdProg_d, holdProg_q;
  logic       openner_q;

  logic [5:0] band_idx;
  logic       band_valid;
  logic       press;
  logic       on_target;
  logic [7:0] lfsr_next;
  logic [5:0] cand;
  logic       cand_ok;
  logic [2:0] miss_inc;
  logic [7:0] hold_inc;

  band_quantizer #(
    .NUM_BANDS(NUM_BANDS),
    .BAND_H   (BAND_H),
    .Y_TOP    (Y_TOP)
  ) u_quant (
    .Clk      (Clk),
    .Reset    (Reset),
    .pickY    (pickY),
    .bandIdx  (band_idx),
    .bandValid(band_valid)
  );

  // Helper terms: press edge, target match, LFSR candidate, counter increments.
  always_comb begin
    press     = openner & ~openner_q;
    on_target = band_valid && (band_idx == curTarget_q);
    lfsr_next = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    cand      = 6'(lfsr_next & CAND_MASK);
    cand_ok   = ({1'b0, cand} < NB7);
    miss_inc  = missCount_q + 3'd1;
    hold_inc  = (holdProg_q == 8'hFF) ? holdProg_q : holdProg_q + 8'd1;
  end

  // Next-state and counter updates; levelStart overrides any transition.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    curTarget_d = curTarget_q;
    pinIdx_d    = pinIdx_q;
    missCount_d = missCount_q;
    holdProg_d  = holdProg_q;

    case (state_q)
      S_IDLE: begin
      end
      S_LOAD: begin
        lfsr_d = lfsr_next;
        if (cand_ok) begin
          curTarget_d = cand;
          state_d     = S_SEEK;
        end
      end
      S_SEEK: begin
        if (press) begin
          if (on_target) begin
            holdProg_d = '0;
            state_d    = S_HOLD;
          end else begin
            missCount_d = miss_inc;
            state_d     = (miss_inc == MAX_M3) ? S_FAIL : S_SEEK;
          end
        end
      end
      S_HOLD: begin
        if (!openner) begin
          state_d = S_SEEK;
        end else if (!on_target) begin
          // A slip beats a same-cycle frame tick.
          missCount_d = miss_inc;
          state_d     = (miss_inc == MAX_M3) ? S_FAIL : S_SEEK;
        end else if (frame_tick) begin
          holdProg_d = hold_inc;
          if (hold_inc == HOLD_8) begin
            state_d = S_PIN_OK;
          end
        end
      end
      S_PIN_OK: begin
        if (pinIdx_q == LAST_PIN) begin
          state_d = S_DONE;
        end else begin
          pinIdx_d   = pinIdx_q + 3'd1;
          holdProg_d = '0;
          state_d    = S_LOAD;
        end
      end
      S_DONE, S_FAIL: begin
      end
      default: state_d = S_IDLE;
    endcase

    if (levelStart) begin
      pinIdx_d    = '0;
      missCount_d = '0;
      holdProg_d  = '0;
      state_d     = S_LOAD;
    end
  end

  // State, LFSR and counter registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      curTarget_q <= '0;
      pinIdx_q    <= '0;
      missCount_q <= '0;
      holdProg_q  <= '0;
      openner_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      curTarget_q <= curTarget_d;
      pinIdx_q    <= pinIdx_d;
      missCount_q <= missCount_d;
      holdProg_q  <= holdProg_d;
      openner_q   <= openner;
    end
  end

  assign levelDone = (state_q == S_DONE);
  assign levelFail = (state_q == S_FAIL);
  assign curTarget = curTarget_q;
  assign bandIdx   = band_idx;
  assign bandValid = band_valid;
  assign pinIdx    = pinIdx_q;
  assign missCount = missCount_q;
  assign holdProg  = holdProg_q;

endmodule

// File: tb/tb_level_pick_seq.sv
// Bench for level_pick_seq: quantiser table, clean pass, misses, hold slip,
// reset/restart and a 20-band instance for target range.
module tb_level_pick_seq;

  logic       Clk = 1'b0;
  logic       Reset, levelStart, openner, frame_tick;
  logic [9:0] pickY;
  logic       levelDone, levelFail, bandValid;
  logic [5:0] curTarget, bandIdx;
  logic [2:0] pinIdx, missCount;
  logic [7:0] holdProg;

  logic       levelStart20;
  logic       levelDone20, levelFail20, bandValid20;
  logic [5:0] curTarget20, bandIdx20;
  logic [2:0] pinIdx20, missCount20;
  logic [7:0] holdProg20;

  always #5 Clk = ~Clk;

  level_pick_seq #(.NUM_PINS(3), .HOLD_CYC(4)) dut (
    .Clk(Clk), .Reset(Reset), .levelStart(levelStart), .openner(openner),
    .pickY(pickY), .frame_tick(frame_tick), .levelDone(levelDone),
    .levelFail(levelFail), .curTarget(curTarget), .bandIdx(bandIdx),
    .bandValid(bandValid), .pinIdx(pinIdx), .missCount(missCount),
    .holdProg(holdProg)
  );

  level_pick_seq #(.NUM_BANDS(20), .NUM_PINS(3), .HOLD_CYC(4)) dut20 (
    .Clk(Clk), .Reset(Reset), .levelStart(levelStart20), .openner(1'b0),
    .pickY(10'd0), .frame_tick(1'b0), .levelDone(levelDone20),
    .levelFail(levelFail20), .curTarget(curTarget20), .bandIdx(bandIdx20),
    .bandValid(bandValid20), .pinIdx(pinIdx20), .missCount(missCount20),
    .holdProg(holdProg20)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string nm;
    int    exp;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic [9:0] y;
    logic       bv;
    logic [5:0] bi;
  } qvec_t;

  logic [7:0] m32, m20;
  int         tgt, n, bad;

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic sb_check(input int act);
    sb_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty actual=%0d required=none", act);
    end else begin
      e = sbq.pop_front();
      chk(e.nm, act, e.exp);
    end
  endtask

  function automatic logic [7:0] step8(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic load32();
    m32 = step8(m32);
    sbq.push_back('{"target32", int'(m32[4:0])});
  endtask

  task automatic load20(output int steps);
    steps = 0;
    do begin
      m20 = step8(m20);
      steps++;
    end while (m20[4:0] >= 5'd20);
    sbq.push_back('{"target20", int'(m20[4:0])});
  endtask

  function automatic logic [9:0] pin_y(input int t);
    return 10'(32 + 14 * t + 7);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_levelDone"}, int'(levelDone), 0);
    chk({tag, "_levelFail"}, int'(levelFail), 0);
    chk({tag, "_curTarget"}, int'(curTarget), 0);
    chk({tag, "_bandIdx"},   int'(bandIdx), 0);
    chk({tag, "_bandValid"}, int'(bandValid), 0);
    chk({tag, "_pinIdx"},    int'(pinIdx), 0);
    chk({tag, "_missCount"}, int'(missCount), 0);
    chk({tag, "_holdProg"},  int'(holdProg), 0);
  endtask

  task automatic ticks(input int cnt, input int base);
    for (int i = 0; i < cnt; i++) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      chk("holdProg_tick", int'(holdProg), base + i + 1);
      cyc();
    end
  endtask

  initial begin
    qvec_t qtab[10];
    qtab[0] = '{10'd31,   1'b0, 6'd0};
    qtab[1] = '{10'd32,   1'b1, 6'd0};
    qtab[2] = '{10'd45,   1'b1, 6'd0};
    qtab[3] = '{10'd46,   1'b1, 6'd1};
    qtab[4] = '{10'd479,  1'b1, 6'd31};
    qtab[5] = '{10'd480,  1'b0, 6'd0};
    qtab[6] = '{10'd100,  1'b1, 6'd4};
    qtab[7] = '{10'd0,    1'b0, 6'd0};
    qtab[8] = '{10'd1023, 1'b0, 6'd0};
    qtab[9] = '{10'd255,  1'b1, 6'd15};

    Reset = 1'b1; levelStart = 1'b0; levelStart20 = 1'b0;
    openner = 1'b0; frame_tick = 1'b0; pickY = '0;
    m32 = 8'hA5; m20 = 8'hA5;
    cyc(); cyc();
    chk_all_zero("reset");
    Reset = 1'b0;
    cyc();

    // Quantiser table
    for (int i = 0; i < 10; i++) begin
      pickY = qtab[i].y;
      sbq.push_back('{"bandValid", int'(qtab[i].bv)});
      sbq.push_back('{"bandIdx", int'(qtab[i].bi)});
      cyc();
      sb_check(int'(bandValid));
      sb_check(int'(bandIdx));
    end

    // Clean pass over three pins
    levelStart = 1'b1; load32(); cyc(); levelStart = 1'b0;
    for (int p = 0; p < 3; p++) begin
      cyc();
      sb_check(int'(curTarget));
      chk("pinIdx", int'(pinIdx), p);
      tgt = int'(m32[4:0]);
      pickY = pin_y(tgt); cyc();
      openner = 1'b1; cyc();
      chk("holdProg_enter", int'(holdProg), 0);
      ticks(4, 0);
      openner = 1'b0;
      if (p < 2) load32();
    end
    chk("levelDone", int'(levelDone), 1);
    chk("levelFail_clean", int'(levelFail), 0);
    bad = 0;
    repeat (100) begin
      cyc();
      if (levelDone !== 1'b1 || levelFail !== 1'b0) bad++;
    end
    chk("levelDone_held", bad, 0);

    // Misses to fail
    levelStart = 1'b1; load32(); cyc(); levelStart = 1'b0;
    chk("restart_levelDone", int'(levelDone), 0);
    cyc();
    sb_check(int'(curTarget));
    tgt = int'(m32[4:0]);
    pickY = pin_y((tgt + 1) % 32); cyc();
    for (int k = 1; k <= 3; k++) begin
      openner = 1'b1; cyc();
      chk("missCount", int'(missCount), k);
      chk("levelFail_miss", int'(levelFail), (k == 3) ? 1 : 0);
      openner = 1'b0; cyc();
    end
    chk("levelDone_fail", int'(levelDone), 0);
    chk("levelFail_held", int'(levelFail), 1);

    // Restart from FAIL
    levelStart = 1'b1; load32(); cyc(); levelStart = 1'b0;
    chk("restart_levelFail", int'(levelFail), 0);
    chk("restart_missCount", int'(missCount), 0);
    chk("restart_pinIdx", int'(pinIdx), 0);
    cyc();
    sb_check(int'(curTarget));

    // Hold interrupted by release, then by a slip
    tgt = int'(m32[4:0]);
    pickY = pin_y(tgt); cyc();
    openner = 1'b1; cyc();
    ticks(2, 0);
    openner = 1'b0; cyc();
    chk("release_missCount", int'(missCount), 0);
    chk("release_holdProg", int'(holdProg), 2);
    openner = 1'b1; cyc();
    chk("repress_holdProg", int'(holdProg), 0);
    ticks(2, 0);
    pickY = pin_y((tgt + 5) % 32); cyc();
    chk("slip_pending_missCount", int'(missCount), 0);
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
    chk("slip_missCount", int'(missCount), 1);
    chk("slip_over_tick_holdProg", int'(holdProg), 2);
    pickY = pin_y(tgt); cyc();
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc();
    chk("held_no_press_holdProg", int'(holdProg), 2);
    chk("held_no_press_missCount", int'(missCount), 1);
    openner = 1'b0; cyc();
    openner = 1'b1; cyc();
    chk("seek_repress_holdProg", int'(holdProg), 0);
    ticks(4, 0);
    openner = 1'b0; load32(); cyc();
    sb_check(int'(curTarget));
    chk("pin1_pinIdx", int'(pinIdx), 1);

    // Reset while in HOLD
    tgt = int'(m32[4:0]);
    pickY = pin_y(tgt); cyc();
    openner = 1'b1; cyc();
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
    chk("pre_reset_holdProg", int'(holdProg), 1);
    Reset = 1'b1; cyc();
    chk_all_zero("reset_hold");
    Reset = 1'b0; openner = 1'b0;
    m32 = 8'hA5; m20 = 8'hA5;
    cyc();
    chk("reset_queue_empty", sbq.size(), 0);
    levelStart = 1'b1; load32(); cyc(); levelStart = 1'b0;
    cyc();
    sb_check(int'(curTarget));

    // Non-power-of-2 band count: target always in range, drawn from the LFSR
    for (int r = 0; r < 200; r++) begin
      levelStart20 = 1'b1; load20(n); cyc(); levelStart20 = 1'b0;
      repeat (n) cyc();
      sb_check(int'(curTarget20));
      chk("target20_range", (curTarget20 < 6'd20) ? 1 : 0, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
